// File: rtl/lsu_pkg.sv
// Shared types and funct3 decode helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores have no unsigned variants, so BU/HU are only legal for loads.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return ~off[0];
            2'b10:   return (off == 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane select and sign/zero extension.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   result = {24'd0, shifted[7:0]};
            F3_HU:   result = {16'd0, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_unit.sv
// Load/store unit: one word-aligned memory access per request, multi-cycle.
// Optional access watchdog enabled with `define LSU_TIMEOUT_EN.
module lsu_mem_unit
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            busy,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic        req_ok;
    logic        timeout_hit;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [31:0] load_result;

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign req_ok    = f3_legal(req_we, req_funct3) && f3_aligned(req_funct3, req_addr[1:0]);

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q;

    // The count reaching the limit is decided one cycle early so the unit
    // spends exactly TIMEOUT_CYCLES cycles in ACCESS.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (state_q == IDLE)
            cnt_q <= '0;
        else if (state_q == ACCESS && !mem_ack)
            cnt_q <= cnt_q + 1'b1;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    // Store lanes: bytes and halves are replicated so any lane sees the data.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = 32'd0;
        if (req_we) begin
            case (req_funct3[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << req_addr[1:0];
                    wdata_d = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    be_d    = 4'b0011 << {req_addr[1], 1'b0};
                    wdata_d = {2{req_wdata[15:0]}};
                end
                default: wdata_d = req_wdata;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = req_ok ? ACCESS : RESP;
            ACCESS:  if (mem_ack || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    lsu_load_align u_align (
        .rdata  (mem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .result (load_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            off_q     <= 2'b00;
            f3_q      <= 3'b000;
        end else begin
            rsp_valid <= 1'b0;
            case (state_q)
                IDLE: if (req_valid) begin
                    if (req_ok) begin
                        mem_req   <= 1'b1;
                        mem_we    <= req_we;
                        mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
                        mem_be    <= be_d;
                        mem_wdata <= wdata_d;
                        off_q     <= req_addr[1:0];
                        f3_q      <= req_funct3;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end
                ACCESS: if (mem_ack) begin
                    mem_req   <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= mem_we ? '0 : load_result;
                end else if (timeout_hit) begin
                    mem_req   <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_unit.sv
// Directed self-checking bench for lsu_mem_unit (default build, no watchdog).
module tb_lsu_mem_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        busy, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int checks   = 0;
    int failures = 0;

    lsu_mem_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for exactly one accepting edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        step();
        req_valid  = 1'b0;
    endtask

    task automatic ack(input logic [31:0] rdata);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        step();
        step();
        check("rst_mem_req",   {31'd0, mem_req},   32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata,          32'd0);
        check("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        check("rst_mem_be",    {28'd0, mem_be},    32'd0);
        check("rst_mem_addr",  mem_addr,           32'd0);
        rst = 1'b0;
        step();
        check("idle_ready", {31'd0, req_ready}, 32'd1);
        check("idle_busy",  {31'd0, busy},      32'd0);

        // LW 0x100, ack one cycle after mem_req rises
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
        check("lw_mem_req",  {31'd0, mem_req},   32'd1);
        check("lw_mem_we",   {31'd0, mem_we},    32'd0);
        check("lw_mem_addr", mem_addr,           32'h0000_0100);
        check("lw_mem_be",   {28'd0, mem_be},    32'hF);
        check("lw_busy",     {31'd0, busy},      32'd1);
        check("lw_ready",    {31'd0, req_ready}, 32'd0);
        check("lw_no_rsp",   {31'd0, rsp_valid}, 32'd0);
        ack(32'hDEAD_BEEF);
        check("lw_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("lw_rsp_rdata", rsp_rdata,          32'hDEAD_BEEF);
        check("lw_rsp_err",   {31'd0, rsp_err},   32'd0);
        check("lw_req_drop",  {31'd0, mem_req},   32'd0);
        step();
        check("lw_rsp_pulse", {31'd0, rsp_valid}, 32'd0);
        check("lw_back_idle", {31'd0, req_ready}, 32'd1);

        // LB / LBU from the top byte lane
        issue(1'b0, 3'b000, 32'h0000_0103, 32'h0);
        check("lb_mem_addr", mem_addr, 32'h0000_0100);
        ack(32'h8011_2233);
        check("lb_rdata", rsp_rdata, 32'hFFFF_FF80);
        step();
        issue(1'b0, 3'b100, 32'h0000_0103, 32'h0);
        ack(32'h8011_2233);
        check("lbu_rdata", rsp_rdata, 32'h0000_0080);
        step();

        // LH / LHU from the upper half, ack delayed three cycles
        issue(1'b0, 3'b001, 32'h0000_0202, 32'h0);
        step();
        step();
        check("lh_wait_req",  {31'd0, mem_req},   32'd1);
        check("lh_wait_rsp",  {31'd0, rsp_valid}, 32'd0);
        ack(32'h8001_1234);
        check("lh_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("lh_rdata",     rsp_rdata,          32'hFFFF_8001);
        step();
        issue(1'b0, 3'b101, 32'h0000_0202, 32'h0);
        ack(32'h8001_1234);
        check("lhu_rdata", rsp_rdata, 32'h0000_8001);
        step();

        // SH 0x102: upper half lanes, replicated data, zero read result
        issue(1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD);
        check("sh_mem_we",    {31'd0, mem_we}, 32'd1);
        check("sh_mem_addr",  mem_addr,        32'h0000_0100);
        check("sh_mem_be",    {28'd0, mem_be}, 32'hC);
        check("sh_mem_wdata", mem_wdata,       32'hABCD_ABCD);
        ack(32'h1234_5678);
        check("sh_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("sh_rsp_rdata", rsp_rdata,          32'd0);
        step();

        // SB 0x101 and SW 0x104
        issue(1'b1, 3'b000, 32'h0000_0101, 32'h1234_565A);
        check("sb_mem_be",    {28'd0, mem_be}, 32'h2);
        check("sb_mem_wdata", mem_wdata,       32'h5A5A_5A5A);
        ack(32'h0);
        step();
        issue(1'b1, 3'b010, 32'h0000_0104, 32'hCAFE_F00D);
        check("sw_mem_be",    {28'd0, mem_be}, 32'hF);
        check("sw_mem_wdata", mem_wdata,       32'hCAFE_F00D);
        check("sw_mem_addr",  mem_addr,        32'h0000_0104);
        ack(32'h0);
        step();

        // Misaligned LW: error response one cycle after accept, no access
        issue(1'b0, 3'b010, 32'h0000_0101, 32'h0);
        check("mis_mem_req",   {31'd0, mem_req},   32'd0);
        check("mis_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("mis_rsp_err",   {31'd0, rsp_err},   32'd1);
        check("mis_rsp_rdata", rsp_rdata,          32'd0);
        step();
        check("mis_idle", {31'd0, req_ready}, 32'd1);

        // Illegal funct3 011 load, and unsigned-byte code used on a store
        issue(1'b0, 3'b011, 32'h0000_0100, 32'h0);
        check("f3_011_mem_req", {31'd0, mem_req}, 32'd0);
        check("f3_011_err",     {31'd0, rsp_err}, 32'd1);
        step();
        issue(1'b1, 3'b100, 32'h0000_0100, 32'h0);
        check("sbu_mem_req", {31'd0, mem_req}, 32'd0);
        check("sbu_err",     {31'd0, rsp_err}, 32'd1);
        step();

        // Misaligned SH at odd address
        issue(1'b1, 3'b001, 32'h0000_0103, 32'h0);
        check("sh_mis_err", {31'd0, rsp_err}, 32'd1);
        step();

        // Reset during ACCESS abandons the access; a later ack is ignored
        issue(1'b0, 3'b010, 32'h0000_0300, 32'h0);
        check("rstmid_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid_mem_req", {31'd0, mem_req},   32'd0);
        check("rstmid_ready",   {31'd0, req_ready}, 32'd1);
        ack(32'hFFFF_FFFF);
        check("rstmid_no_rsp",  {31'd0, rsp_valid}, 32'd0);
        check("rstmid_idle",    {31'd0, busy},      32'd0);

        // A good access still works afterwards
        issue(1'b0, 3'b010, 32'h0000_0400, 32'h0);
        ack(32'h0BAD_F00D);
        check("post_rst_rdata", rsp_rdata,        32'h0BAD_F00D);
        check("post_rst_err",   {31'd0, rsp_err}, 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

endmodule

// File: doc/lsu_mem_unit.md
Name: lsu_mem_unit

Overview:
- Load/store unit between the execute-stage address/data and the data-memory port.
- Issues one word-aligned memory access per request and generates byte enables and lane-replicated store data.
- Returns a sign- or zero-extended load result, which drives the memory-data input of the writeback result select.
- Multi-cycle: the core stalls on busy until the response is returned.

Parameters:
- XLEN, 32, data/address width; only 32 supported.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles. Used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code.
- req_addr  in  XLEN  byte address (rs1 + imm).
- req_wdata  in  XLEN  store data (rs2).
- busy  out  1  request in flight; core stalls on it.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal funct3, or timeout.
- mem_req  out  1  memory access strobe, held until ack.
- mem_we  out  1  write enable.
- mem_addr  out  XLEN  {addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_ack  in  1  access done; read data valid in the same cycle.
- mem_rdata  in  XLEN  read word.

Behaviour:
- Reset: state IDLE. All registered outputs 0 (mem_req, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid, rsp_rdata, rsp_err). Reset applied mid-access abandons the access; mem_req is low in the cycle after the reset edge.
- FSM:
  - IDLE: req_ready=1, busy=0. Accept on req_valid&req_ready.
    - Legal and aligned: go to ACCESS.
    - Otherwise: go to RESP with rsp_err=1; no mem_req is issued.
  - ACCESS: mem_req=1 with address/be/wdata registered at accept and stable. On mem_ack, capture and extend mem_rdata, then go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE. busy=1 in ACCESS and RESP.
- funct3 decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal and sets rsp_err.
- Alignment: H requires addr[0]=0; W requires addr[1:0]=00. Any byte address is legal.
- Store lanes:
  - SB: be = 0001<<addr[1:0], wdata = {4{b}}.
  - SH: be = 0011<<{addr[1],0}, wdata = {2{h}}.
  - SW: be = 1111.
- Loads: be = 1111. Select lane = mem_rdata >> 8*addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- Latency: accept at edge E0; mem_req high from E0. Ack at E1 gives rsp_valid in the cycle after E1. Minimum is 2 cycles from accept to response. Error path gives response 1 cycle after accept.
- mem_ack while mem_req=0 is ignored. A new request can be accepted the cycle after the RESP cycle.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When the count reaches TIMEOUT_CYCLES, drop mem_req and go to RESP with rsp_err=1 and rsp_rdata=0.
  - An ack arriving in the same cycle as the limit wins.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Package lsu_pkg: state enum (IDLE, ACCESS, RESP) and funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
- One sub-module: lsu_load_align, a combinational lane select plus extend (rdata, offset, funct3 -> result).

Test Plan:
- LW 0x100, mem_rdata=0xDEADBEEF, ack 1 cycle after mem_req -> mem_be=1111; rsp_valid 2 cycles after accept; rsp_rdata=0xDEADBEEF; rsp_err=0.
- LB 0x103 and LBU 0x103, rdata=0x80112233 -> 0xFFFFFF80 and 0x00000080 respectively.
- SH 0x102, wdata=0x0000ABCD -> mem_we=1, mem_addr=0x100, mem_be=1100, mem_wdata=0xABCDABCD; rsp_rdata=0.
- LW 0x101 and funct3=011 -> no mem_req; rsp_valid 1 cycle after accept with rsp_err=1.
- rst asserted during ACCESS with ack withheld -> mem_req=0 and req_ready=1 the next cycle; a later ack is ignored.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never given -> rsp_err=1 after 4 ACCESS cycles, then IDLE.
